// File: rtl/posit_sign_restore_pkg.sv
// Shared posit definitions: lane-mode encoding and chunk geometry for the
// 32-bit SIMD posit datapath (1x32, 2x16, 4x8 lanes).
package posit_sign_restore_pkg;

  localparam int WORD_W   = 32;
  localparam int CHUNK_W  = 8;
  localparam int N_CHUNKS = 4;

  // Mode 2'b11 also selects a single 32-bit lane; only bit 1 matters for it.
  typedef enum logic [1:0] {
    MODE_8  = 2'b00,
    MODE_16 = 2'b01,
    MODE_32 = 2'b10
  } mode_e;

  function automatic logic is_mode32(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic is_mode8(input logic [1:0] mode);
    return mode == MODE_8;
  endfunction

endpackage

// File: rtl/posit_chunk_neg.sv
// One 8-bit slice of the conditional two's complement: optional invert,
// then add the carry-in, exposing the carry-out for the next slice.
module posit_chunk_neg
  import posit_sign_restore_pkg::*;
(
  input  logic [CHUNK_W-1:0] mag,
  input  logic               inv,
  input  logic               cin,
  output logic [CHUNK_W-1:0] res,
  output logic               cout
);

  logic [CHUNK_W:0] sum;

  assign sum  = {1'b0, mag ^ {CHUNK_W{inv}}} + {{CHUNK_W{1'b0}}, cin};
  assign res  = sum[CHUNK_W-1:0];
  assign cout = sum[CHUNK_W];

endmodule

// File: rtl/posit_sign_restore.sv
// Two-stage SIMD sign restoration: re-applies per-lane signs to rounded posit
// magnitudes. Optional NaR flags on out_nar when POSIT_SIGNR_NAR_EN is defined.
module posit_sign_restore
  import posit_sign_restore_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mode,
  input  logic [WORD_W-1:0]   in_mag,
  input  logic [N_CHUNKS-1:0] in_sign,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic [1:0]          out_mode
`ifdef POSIT_SIGNR_NAR_EN
  ,
  output logic [N_CHUNKS-1:0] out_nar
`endif
);

  // ---------------- handshake ----------------
  logic s1_valid;
  logic s1_advance;
  logic in_fire;

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign in_fire    = in_valid && in_ready;

  // ---------------- stage 1: sign steering, chunks 0-1 ----------------
  logic [N_CHUNKS-1:0] sgn;
  logic                c1;
  logic                co0;
  logic                co1;
  logic [15:0]         lo_res;
  logic [15:0]         hi_x;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sgn = {N_CHUNKS{in_sign[0]}};
    if (is_mode8(in_mode)) begin
      sgn = in_sign;
    end else if (!is_mode32(in_mode)) begin
      sgn = {{2{in_sign[1]}}, {2{in_sign[0]}}};
    end
  end

  // Chunk 1 continues lane 0's carry chain unless it starts its own 8-bit lane.
  assign c1   = is_mode8(in_mode) ? sgn[1] : co0;
  assign hi_x = in_mag[31:16] ^ {{CHUNK_W{sgn[3]}}, {CHUNK_W{sgn[2]}}};

  posit_chunk_neg u_chunk0 (
    .mag (in_mag[7:0]),
    .inv (sgn[0]),
    .cin (sgn[0]),
    .res (lo_res[7:0]),
    .cout(co0)
  );

  posit_chunk_neg u_chunk1 (
    .mag (in_mag[15:8]),
    .inv (sgn[1]),
    .cin (c1),
    .res (lo_res[15:8]),
    .cout(co1)
  );

`ifdef POSIT_SIGNR_NAR_EN
  logic [N_CHUNKS-1:0] nar_in;
  logic [N_CHUNKS-1:0] s1_nar;

  always_comb begin
    nar_in = '0;
    if (is_mode32(in_mode)) begin
      nar_in[0] = (in_mag == 32'h8000_0000);
    end else if (!is_mode8(in_mode)) begin
      nar_in[0] = (in_mag[15:0]  == 16'h8000);
      nar_in[1] = (in_mag[31:16] == 16'h8000);
    end else begin
      for (int k = 0; k < N_CHUNKS; k++) begin
        nar_in[k] = (in_mag[k*CHUNK_W +: CHUNK_W] == 8'h80);
      end
    end
  end
`endif

  logic [15:0] s1_low;
  logic [15:0] s1_hi_x;
  logic [1:0]  s1_sgn_hi;
  logic        s1_co1;
  logic [1:0]  s1_mode;

  // NOTE: the data registers are reset as well as the valid bits: the output
  // word must read zero after reset, and this keeps both stages deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_low    <= '0;
      s1_hi_x   <= '0;
      s1_sgn_hi <= '0;
      s1_co1    <= 1'b0;
      s1_mode   <= '0;
`ifdef POSIT_SIGNR_NAR_EN
      s1_nar    <= '0;
`endif
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_fire) begin
        s1_low    <= lo_res;
        s1_hi_x   <= hi_x;
        s1_sgn_hi <= sgn[3:2];
        s1_co1    <= co1;
        s1_mode   <= in_mode;
`ifdef POSIT_SIGNR_NAR_EN
        s1_nar    <= nar_in;
`endif
      end
    end
  end

  // ---------------- stage 2: chunks 2-3 ----------------
  // Upper chunks were already inverted in stage 1; only the carry add remains.
  logic        c2;
  logic        c3;
  logic        co2;
  logic        co3_unused;
  logic [15:0] hi_res;

  assign c2 = is_mode32(s1_mode) ? s1_co1       : s1_sgn_hi[0];
  assign c3 = is_mode8(s1_mode)  ? s1_sgn_hi[1] : co2;

  posit_chunk_neg u_chunk2 (
    .mag (s1_hi_x[7:0]),
    .inv (1'b0),
    .cin (c2),
    .res (hi_res[7:0]),
    .cout(co2)
  );

  posit_chunk_neg u_chunk3 (
    .mag (s1_hi_x[15:8]),
    .inv (1'b0),
    .cin (c3),
    .res (hi_res[15:8]),
    .cout(co3_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= '0;
`ifdef POSIT_SIGNR_NAR_EN
      out_nar   <= '0;
`endif
    end else if (s1_advance) begin
      out_valid <= s1_valid;
      // Load only real words so a bubble never disturbs the held output.
      if (s1_valid) begin
        out_data <= {hi_res, s1_low};
        out_mode <= s1_mode;
`ifdef POSIT_SIGNR_NAR_EN
        out_nar  <= s1_nar;
`endif
      end
    end
  end

endmodule

// File: tb/tb_posit_sign_restore.sv
// Self-checking bench for posit_sign_restore: directed cases, backpressure,
// reset in flight and a randomized in-order scoreboard against a lane model.
module tb_posit_sign_restore;
  import posit_sign_restore_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [31:0] in_mag;
  logic [3:0]  in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
`ifdef POSIT_SIGNR_NAR_EN
  logic [3:0]  out_nar;
`endif

  always #5 clk = ~clk;

  posit_sign_restore dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_mag   (in_mag),
    .in_sign  (in_sign),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mode (out_mode)
`ifdef POSIT_SIGNR_NAR_EN
    ,
    .out_nar  (out_nar)
`endif
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] mag;
    logic [3:0]  sign;
    bit          has_exp;
    logic [31:0] exp_data;
  } stim_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
    logic [3:0]  nar;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_accept = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Lane-level reference: each lane is negated modulo 2^w when its sign is set.
  function automatic exp_t model(input stim_t s);
    exp_t            e;
    int              w;
    longint unsigned mask;
    longint unsigned m;
    w    = s.mode[1] ? 32 : (s.mode[0] ? 16 : 8);
    mask = (64'd1 << w) - 1;
    e.data = '0;
    e.nar  = '0;
    e.mode = s.mode;
    for (int l = 0; l < 32 / w; l++) begin
      m = ({32'd0, s.mag} >> (l * w)) & mask;
      if (m == (64'd1 << (w - 1))) e.nar[l] = 1'b1;
      if (s.sign[l]) m = (mask + 1 - m) & mask;
      e.data = e.data | 32'(m << (l * w));
    end
    if (s.has_exp) e.data = s.exp_data;
    return e;
  endfunction

  function automatic stim_t mk(input logic [1:0] mode, input logic [31:0] mag,
                               input logic [3:0] sign, input bit has_exp,
                               input logic [31:0] exp_data);
    stim_t s;
    s.mode = mode; s.mag = mag; s.sign = sign;
    s.has_exp = has_exp; s.exp_data = exp_data;
    return s;
  endfunction

  // One clock cycle: drive at posedge+1, observe at the following negedge.
  task automatic cycle(input int valid_pct, input int ready_pct);
    if (stim_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      in_valid = 1'b1;
      in_mode  = stim_q[0].mode;
      in_mag   = stim_q[0].mag;
      in_sign  = stim_q[0].sign;
    end else begin
      in_valid = 1'b0;
      in_mode  = 2'($urandom);
      in_mag   = $urandom;
      in_sign  = 4'($urandom);
    end
    out_ready = ($urandom_range(99) < ready_pct);
    @(negedge clk);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        check("sb_data", out_data, exp_q[0].data);
        check("sb_mode", 32'(out_mode), 32'(exp_q[0].mode));
`ifdef POSIT_SIGNR_NAR_EN
        check("sb_nar", 32'(out_nar), 32'(exp_q[0].nar));
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(stim_q[0]));
      void'(stim_q.pop_front());
      n_accept++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input int valid_pct, input int ready_pct);
    int c = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && c < budget) begin
      cycle(valid_pct, ready_pct);
      c++;
    end
    check("drain_left", 32'(stim_q.size() + exp_q.size()), 32'd0);
  endtask

  // Sends one word into an empty pipe and samples the result after edge N+1.
  task automatic single(input stim_t s, output logic [31:0] data, output logic [3:0] nar);
    in_valid = 1'b1; in_mode = s.mode; in_mag = s.mag; in_sign = s.sign;
    out_ready = 1'b1;
    @(negedge clk);
    check("single_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_mag = $urandom; in_sign = 4'($urandom); in_mode = 2'($urandom);
    @(negedge clk);
    check("lat_early_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 32'd1);
    data = out_data;
    nar  = '0;
`ifdef POSIT_SIGNR_NAR_EN
    nar  = out_nar;
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_drained", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  nr;
    stim_t       s;
    logic [1:0]  rm;

    in_valid = 1'b0; in_mode = '0; in_mag = '0; in_sign = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_mode", 32'(out_mode), 32'd0);
`ifdef POSIT_SIGNR_NAR_EN
    check("rst_out_nar", 32'(out_nar), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Latency and the first directed value.
    single(mk(MODE_32, 32'h0000_0001, 4'b0001, 0, '0), d, nr);
    check("lat_data_m32_neg1", d, 32'hFFFF_FFFF);

    // Directed table, streamed back to back (includes the mode switch pair).
    stim_q.push_back(mk(MODE_32, 32'h0000_0000, 4'b0001, 1, 32'h0000_0000));
    stim_q.push_back(mk(MODE_16, 32'h0001_0002, 4'b0010, 1, 32'hFFFF_0002));
    stim_q.push_back(mk(MODE_16, 32'h0001_0002, 4'b0011, 1, 32'hFFFF_FFFE));
    stim_q.push_back(mk(MODE_8,  32'h0102_0304, 4'b0101, 1, 32'h01FE_03FC));
    stim_q.push_back(mk(MODE_32, 32'h0000_0100, 4'b0001, 1, 32'hFFFF_FF00));
    stim_q.push_back(mk(MODE_8,  32'h0000_0100, 4'b0001, 1, 32'h0000_0100));
    stim_q.push_back(mk(MODE_8,  32'h8080_8080, 4'b1111, 1, 32'h8080_8080));
    stim_q.push_back(mk(MODE_16, 32'h8000_0000, 4'b0011, 1, 32'h8000_0000));
    stim_q.push_back(mk(2'b11,   32'h8000_0000, 4'b1111, 1, 32'h8000_0000));
    drain(200, 100, 100);

    // Backpressure: only two words fit while the output is stalled.
    for (int i = 0; i < 4; i++) stim_q.push_back(mk(2'($urandom), $urandom, 4'($urandom), 0, '0));
    n_accept = 0;
    repeat (4) cycle(100, 0);
    check("bp_accepts", 32'(n_accept), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    drain(100, 100, 100);

    // Randomized scoreboard with random stalls on both sides.
    for (int i = 0; i < 1000; i++) begin
      rm = 2'($urandom);
      case ($urandom_range(7))
        0:       s = mk(rm, 32'h0000_0000, 4'($urandom), 0, '0);
        1:       s = mk(rm, 32'h8000_8080, 4'($urandom), 0, '0);
        default: s = mk(rm, $urandom, 4'($urandom), 0, '0);
      endcase
      stim_q.push_back(s);
    end
    drain(20000, 70, 60);

    // Reset with two words in flight.
    stim_q.push_back(mk(MODE_32, 32'h1234_5678, 4'b0001, 0, '0));
    stim_q.push_back(mk(MODE_8,  32'h0102_0304, 4'b1111, 0, '0));
    repeat (3) cycle(100, 0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
`ifdef POSIT_SIGNR_NAR_EN
    check("midrst_out_nar", 32'(out_nar), 32'd0);
`endif
    stim_q.delete();
    exp_q.delete();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // 16-bit word with a NaR upper lane.
    single(mk(MODE_16, 32'h8000_0001, 4'b0000, 0, '0), d, nr);
    check("nar_word_data", d, 32'h8000_0001);
`ifdef POSIT_SIGNR_NAR_EN
    check("nar_flags_m16", 32'(nr), 32'h0000_0002);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
